// File: rtl/ctrl_unit_mc.sv
// ctrl_unit_mc: multicycle Moore control FSM for the RV64 datapath.
// It steps each instruction through fetch, a configurable I-memory wait,
// PC increment and decode. It then runs the execute, branch, jump,
// load/store or exception sequence. Load/store sizes are decoded from funct3
// and the address is checked for alignment. Data-memory access uses a ready
// handshake with a timeout. Faults go to a cause-coded exception path.
//
// Strobes and selects come from the state register. Field-dependent selects
// (size, branch op, ALU op, write-back source) also use the held IR contents.
// The only exception is LoadMDR, which is qualified by mem_ready.
//
// Ports:
//   clk, Reset (async, active-high; forces every output low while high)
//   instruction[31:0] IR contents, alu_lo[2:0] ALUOut low bits, mem_ready
//   PCWrite, PCWriteCond, PCSrc[1:0], ALUSrcA, ALUSrcB[1:0], ALUFunct[2:0]
//   ld_en[4:0] {LoadIR,LoadRegA,LoadRegB,LoadALUOut,LoadMDR}
//   mem_req, DMemWrite, WriteReg, MemToReg[3:0], BranchOp[1:0]
//   ShiftControl[1:0], tam[1:0], LoadExc, SrcExc[1:0], halted, state
//
// Build option: define CTRL_MULDIV_EN to route R-type funct7=0000001
// through a multiply/divide unit. This adds the muldiv_start output and the
// muldiv_done input. When undefined, those encodings are illegal.
module ctrl_unit_mc #(
  parameter int IMEM_WAIT   = 1,
  parameter int MEM_TIMEOUT = 15,
  parameter int STATE_W     = 6
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic [31:0]        instruction,
  input  logic [2:0]         alu_lo,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic [1:0]         PCSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUFunct,
  output logic [4:0]         ld_en,
  output logic               mem_req,
  output logic               DMemWrite,
  output logic               WriteReg,
  output logic [3:0]         MemToReg,
  output logic [1:0]         BranchOp,
  output logic [1:0]         ShiftControl,
  output logic [1:0]         tam,
  output logic               LoadExc,
  output logic [1:0]         SrcExc,
  output logic               halted,
`ifdef CTRL_MULDIV_EN
  output logic               muldiv_start,
  input  logic               muldiv_done,
`endif
  output logic [STATE_W-1:0] state
);

  localparam logic [STATE_W-1:0] S_FETCH   = 'd0;
  localparam logic [STATE_W-1:0] S_FWAIT   = 'd1;
  localparam logic [STATE_W-1:0] S_PCINC   = 'd2;
  localparam logic [STATE_W-1:0] S_DECODE  = 'd3;
  localparam logic [STATE_W-1:0] S_EXEC    = 'd4;
  localparam logic [STATE_W-1:0] S_WB      = 'd5;
  localparam logic [STATE_W-1:0] S_BR      = 'd6;
  localparam logic [STATE_W-1:0] S_BR_WAIT = 'd7;
  localparam logic [STATE_W-1:0] S_LINK    = 'd8;
  localparam logic [STATE_W-1:0] S_JADDR   = 'd9;
  localparam logic [STATE_W-1:0] S_JUMP    = 'd10;
  localparam logic [STATE_W-1:0] S_ADDR    = 'd11;
  localparam logic [STATE_W-1:0] S_ALIGN   = 'd12;
  localparam logic [STATE_W-1:0] S_MEM     = 'd13;
  localparam logic [STATE_W-1:0] S_LD_WB   = 'd14;
  localparam logic [STATE_W-1:0] S_EXC     = 'd15;
  localparam logic [STATE_W-1:0] S_EXC_VEC = 'd16;
  localparam logic [STATE_W-1:0] S_HALT    = 'd17;
  localparam logic [STATE_W-1:0] S_MD_ST   = 'd18;
  localparam logic [STATE_W-1:0] S_MD_WAIT = 'd19;

  localparam logic [7:0] IW_LAST = 8'(IMEM_WAIT - 1);
  localparam logic [7:0] TMO     = 8'(MEM_TIMEOUT);

  logic [STATE_W-1:0] state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [1:0]         cause_q, cause_d;

  // Instruction field decode
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic       is_r, is_i, is_lui, is_br, is_jal, is_jalr, is_ld, is_st;
  logic       is_ebreak, is_md, r_ok, i_ok, br_ok;
  logic [1:0] size, br_op, shift_sel;
  logic [2:0] exec_funct;
  logic [3:0] wb_sel;
  logic       misaligned;

  assign opcode    = instruction[6:0];
  assign rd        = instruction[11:7];
  assign funct3    = instruction[14:12];
  assign funct7    = instruction[31:25];
  assign is_r      = (opcode == 7'b0110011);
  assign is_i      = (opcode == 7'b0010011);
  assign is_lui    = (opcode == 7'b0110111);
  assign is_br     = (opcode == 7'b1100011);
  assign is_jal    = (opcode == 7'b1101111);
  assign is_jalr   = (opcode == 7'b1100111) && (funct3 == 3'b000);
  assign is_ld     = (opcode == 7'b0000011);
  assign is_st     = (opcode == 7'b0100011) && !funct3[2];
  assign is_ebreak = (instruction == 32'h0010_0073);
  assign is_md     = is_r && (funct7 == 7'b0000001);

  assign r_ok = ((funct7 == 7'b0000000) && (funct3 == 3'b000 || funct3 == 3'b001 ||
                  funct3 == 3'b010 || funct3 == 3'b101 || funct3 == 3'b111)) ||
                ((funct7 == 7'b0100000) && (funct3 == 3'b000 || funct3 == 3'b101));
  // RV64 immediate shifts carry a 6-bit shamt, so only instruction[31:26] is the opcode extension.
  assign i_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                ((funct3 == 3'b001) && (instruction[31:26] == 6'b000000)) ||
                ((funct3 == 3'b101) && (instruction[31:26] == 6'b000000 ||
                                        instruction[31:26] == 6'b010000));
  assign br_ok = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                 (funct3 == 3'b100) || (funct3 == 3'b101);

  // funct3[1:0] encodes log2(bytes); tam counts the other way.
  assign size       = ~funct3[1:0];
  assign misaligned = (size == 2'b00) ? (alu_lo != 3'b000) :
                      (size == 2'b01) ? (alu_lo[1:0] != 2'b00) :
                      (size == 2'b10) ? alu_lo[0] : 1'b0;
  assign br_op      = (funct3 == 3'b001) ? 2'b01 : (funct3 == 3'b101) ? 2'b10 :
                      (funct3 == 3'b100) ? 2'b11 : 2'b00;
  assign shift_sel  = (funct3 == 3'b101) ? (instruction[30] ? 2'b10 : 2'b01) : 2'b00;
  // slt/slti compare through a subtract.
  assign exec_funct = ((is_r && funct7 == 7'b0100000 && funct3 == 3'b000) ||
                       funct3 == 3'b010) ? 3'b010 :
                      (is_r && funct3 == 3'b111) ? 3'b011 : 3'b001;
  assign wb_sel     = is_lui ? 4'd2 : is_md ? 4'd6 :
                      (funct3 == 3'b010) ? 4'd5 :
                      (funct3 == 3'b001 || funct3 == 3'b101) ? 4'd4 : 4'd0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH: begin
        cnt_d = '0;
        state_d = (IMEM_WAIT == 0) ? S_PCINC : S_FWAIT;
      end
      S_FWAIT: begin
        if (cnt_q == IW_LAST) begin
          state_d = S_PCINC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_PCINC: state_d = S_DECODE;
      S_DECODE: begin
        if (is_ebreak)                          state_d = S_HALT;
        else if ((is_r && r_ok) || (is_i && i_ok))
          state_d = (is_i && funct3 == 3'b000 && rd == 5'd0) ? S_FETCH : S_EXEC;
`ifdef CTRL_MULDIV_EN
        else if (is_md)                         state_d = S_MD_ST;
`endif
        else if (is_lui)                        state_d = S_WB;
        else if (is_br && br_ok)                state_d = S_BR;
        else if (is_jal || is_jalr)             state_d = S_LINK;
        else if (is_ld || is_st)                state_d = S_ADDR;
        else begin
          state_d = S_EXC;
          cause_d = 2'b00;
        end
      end
      S_EXEC:    state_d = S_WB;
      S_WB:      state_d = S_FETCH;
      S_BR:      state_d = S_BR_WAIT;
      S_BR_WAIT: state_d = S_FETCH;
      S_LINK:    state_d = is_jalr ? S_JADDR : S_JUMP;
      S_JADDR:   state_d = S_JUMP;
      S_JUMP:    state_d = S_FETCH;
      S_ADDR:    state_d = S_ALIGN;
      S_ALIGN: begin
        if (misaligned) begin
          state_d = S_EXC;
          cause_d = 2'b10;
        end else begin
          state_d = S_MEM;
          cnt_d   = 8'd1;   // counter holds the 1-based MEM cycle number
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = is_ld ? S_LD_WB : S_FETCH;
          cnt_d   = '0;
        end else if (cnt_q == TMO) begin
          state_d = S_EXC;
          cause_d = 2'b01;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_LD_WB:   state_d = S_FETCH;
      S_EXC:     state_d = S_EXC_VEC;
      S_EXC_VEC: state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
`ifdef CTRL_MULDIV_EN
      S_MD_ST:   state_d = S_MD_WAIT;
      S_MD_WAIT: if (muldiv_done) state_d = S_WB;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  assign state = state_q;

  always_comb begin
    PCWrite = 1'b0; PCWriteCond = 1'b0; PCSrc = 2'b00; ALUSrcA = 1'b0;
    ALUSrcB = 2'b00; ALUFunct = 3'b000; ld_en = 5'b00000; mem_req = 1'b0;
    DMemWrite = 1'b0; WriteReg = 1'b0; MemToReg = 4'd0; BranchOp = 2'b00;
    ShiftControl = 2'b00; tam = 2'b00; LoadExc = 1'b0; SrcExc = 2'b00;
    halted = 1'b0;
`ifdef CTRL_MULDIV_EN
    muldiv_start = 1'b0;
`endif
    // Reset is asynchronous, so outputs drop in the same cycle it rises.
    if (!Reset) begin
      case (state_q)
        S_FETCH:  ld_en = 5'b10000;
        S_PCINC:  begin PCWrite = 1'b1; ALUSrcB = 2'b01; ALUFunct = 3'b001; end
        S_DECODE: begin ALUSrcB = 2'b11; ALUFunct = 3'b001; ld_en = 5'b01110; end
        S_EXEC: begin
          ALUSrcA = 1'b1; ALUSrcB = is_r ? 2'b00 : 2'b10;
          ALUFunct = exec_funct; ld_en = 5'b00010; ShiftControl = shift_sel;
        end
        S_WB: begin WriteReg = 1'b1; MemToReg = wb_sel; ShiftControl = shift_sel; end
        S_BR: begin
          ALUSrcA = 1'b1; ALUFunct = 3'b010; PCWriteCond = 1'b1;
          PCSrc = 2'b01; BranchOp = br_op;
        end
        S_LINK:   begin WriteReg = 1'b1; MemToReg = 4'd3; end
        S_JADDR:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUFunct = 3'b001; ld_en = 5'b00010; end
        S_JUMP:   begin PCWrite = 1'b1; PCSrc = 2'b01; end
        S_ADDR: begin
          ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUFunct = 3'b001; ld_en = 5'b00010; tam = size;
        end
        S_ALIGN:  tam = size;
        S_MEM: begin
          mem_req = 1'b1; DMemWrite = is_st; tam = size;
          ld_en = {4'b0000, is_ld & mem_ready};
        end
        S_LD_WB:   begin WriteReg = 1'b1; MemToReg = 4'd1; tam = size; end
        S_EXC:     begin LoadExc = 1'b1; SrcExc = cause_q; end
        S_EXC_VEC: begin PCWrite = 1'b1; PCSrc = 2'b10; end
        S_HALT:    halted = 1'b1;
`ifdef CTRL_MULDIV_EN
        S_MD_ST:   muldiv_start = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule
